// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the memory-port arbiter, the CPU and the DMA request channel.
// Holds the FSM encoding, request-channel widths and the request payload struct.
package mem_bus_arbiter_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    typedef enum logic [2:0] {
        S_IDLE = 3'b001,
        S_REQ  = 3'b010,
        S_RESP = 3'b100
    } state_e;

    typedef struct packed {
        logic              wr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
    } req_data_t;

    // Width of an index into N masters; never zero so single-master builds still elaborate.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Request/response memory channel, N lanes wide (lane i at slice [i*W +: W]).
// Handshakes: a request transfers in a cycle where (wen|ren) and req_ready are both high;
// read data transfers in a cycle where rvalid and rready are both high.
interface mem_bus_arbiter_if
    import mem_bus_arbiter_pkg::*;
#(
    parameter int N  = 1,
    parameter int AW = ADDR_W
);
    logic [N*AW-1:0]     addr;
    logic [N-1:0]        wen;
    logic [N-1:0]        ren;
    logic [N*DATA_W-1:0] wdata;
    logic [N*STRB_W-1:0] wstrb;
    logic [N-1:0]        req_ready;
    logic [N*DATA_W-1:0] rdata;
    logic [N-1:0]        rvalid;
    logic [N-1:0]        rready;

    modport master (
        output addr, wen, ren, wdata, wstrb, rready,
        input  req_ready, rdata, rvalid
    );

    modport slave (
        input  addr, wen, ren, wdata, wstrb, rready,
        output req_ready, rdata, rvalid
    );
endinterface

// File: rtl/mem_bus_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester found searching upward
// from (last_i + 1) with wrap, returned as one-hot grant plus index.
module rr_picker
    import mem_bus_arbiter_pkg::*;
#(
    parameter int NUM_M = 3,
    localparam int IW   = idx_w(NUM_M)
) (
    input  logic [NUM_M-1:0] req_i,
    input  logic [IW-1:0]    last_i,
    output logic [NUM_M-1:0] gnt_o,
    output logic [IW-1:0]    idx_o,
    output logic             valid_o
);

    always_comb begin : pick
        int c;
        c       = 0;
        gnt_o   = '0;
        idx_o   = '0;
        for (int k = 1; k <= NUM_M; k++) begin
            c = (int'(last_i) + k) % NUM_M;
            if ((gnt_o == '0) && req_i[IW'(c)]) begin
                gnt_o[IW'(c)] = 1'b1;
                idx_o         = IW'(c);
            end
        end
        valid_o = |req_i;
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory port between NUM_M masters, one transaction
// in flight; the grant is held until the read-data handshake so responses route back.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int NUM_M = 3,
    parameter int AW    = ADDR_W
) (
    input  logic                clk,
    input  logic                rst,
    mem_bus_arbiter_if.slave    m_bus,
    mem_bus_arbiter_if.master   mem_bus,
    output logic [31:0]         contend_cnt,
    output state_e              dbg_state_o
);

    localparam int IW = idx_w(NUM_M);

    state_e           state_q;
    logic [NUM_M-1:0] grant_q;
    logic [IW-1:0]    gnt_idx_q;
    logic [IW-1:0]    last_q;
    logic             is_wr_q;
    logic [31:0]      cnt_q, cnt_d;

    logic [NUM_M-1:0] req_vec;
    logic [NUM_M-1:0] pick_gnt;
    logic [IW-1:0]    pick_idx;
    logic             pick_valid;
    logic             in_req, in_resp;
    logic [NUM_M-1:0] waiting;
    req_data_t        cur_req;

    assign req_vec = m_bus.wen | m_bus.ren;
    assign in_req  = (state_q == S_REQ);
    assign in_resp = (state_q == S_RESP);

    rr_picker #(.NUM_M(NUM_M)) u_picker (
        .req_i   (req_vec),
        .last_i  (last_q),
        .gnt_o   (pick_gnt),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    // A master asserting both wen and ren is treated as a write.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            grant_q   <= '0;
            gnt_idx_q <= '0;
            last_q    <= IW'(NUM_M - 1);
            is_wr_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pick_valid) begin
                        grant_q   <= pick_gnt;
                        gnt_idx_q <= pick_idx;
                        last_q    <= pick_idx;
                        is_wr_q   <= m_bus.wen[pick_idx];
                        state_q   <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (mem_bus.req_ready) begin
                        state_q <= is_wr_q ? S_IDLE : S_RESP;
                        if (is_wr_q) grant_q <= '0;
                    end
                end
                S_RESP: begin
                    if (mem_bus.rvalid && m_bus.rready[gnt_idx_q]) begin
                        state_q <= S_IDLE;
                        grant_q <= '0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

    always_comb begin
        cur_req       = '0;
        cur_req.wr    = is_wr_q;
        cur_req.wdata = m_bus.wdata[int'(gnt_idx_q)*DATA_W +: DATA_W];
        cur_req.wstrb = m_bus.wstrb[int'(gnt_idx_q)*STRB_W +: STRB_W];
    end

    // Address and write data follow the grant index even when not valid.
    assign mem_bus.addr   = m_bus.addr[int'(gnt_idx_q)*AW +: AW];
    assign mem_bus.wdata  = cur_req.wdata;
    assign mem_bus.wstrb  = in_req ? cur_req.wstrb : '0;
    assign mem_bus.wen    = in_req & cur_req.wr;
    assign mem_bus.ren    = in_req & ~cur_req.wr;
    assign mem_bus.rready = in_resp & m_bus.rready[gnt_idx_q];

    assign m_bus.req_ready = (in_req && mem_bus.req_ready) ? grant_q : '0;
    assign m_bus.rvalid    = (in_resp && mem_bus.rvalid) ? grant_q : '0;
    assign m_bus.rdata     = {NUM_M{mem_bus.rdata}};

    // A requester counts as waiting unless it is the one currently presenting downstream.
    assign waiting = req_vec & ~(in_req ? grant_q : '0);
    assign cnt_d   = cnt_q + ((|waiting) ? 32'd1 : 32'd0);

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign contend_cnt = cnt_q;
    assign dbg_state_o = state_q;

endmodule
